// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the FPGA-side initiator of the multiplexed address/data MCU bus.
// Widths, FSM state encoding and the address map of the FPGA target decoder.
package mcu_bus_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int AHI_W  = ADDR_W - DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AHOLD,
    ST_DATA,
    ST_RECOV
  } bus_state_e;

  // Target decoder address map; DDS RAM is selected by A[18:15] alone.
  localparam logic [3:0]        DDS_RAM_BASE = 4'b1010;
  localparam logic [ADDR_W-1:0] FREQ_LO_ADDR = 19'h58400;
  localparam logic [ADDR_W-1:0] FREQ_HI_ADDR = 19'h58800;
  localparam logic [ADDR_W-1:0] FIFO_AD_ADDR = 19'h58001;
  localparam logic [ADDR_W-1:0] SPI_ADDR     = 19'h58002;

  function automatic logic is_dds_ram(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ADDR_W-4] == DDS_RAM_BASE;
  endfunction

endpackage

// File: rtl/mcu_bus_master_if.sv
// User request/ack handshake plus MCU bus pins of the bus initiator.
// The master modport is the initiator's view; slave is the user/target side.
interface mcu_bus_master_if;
  import mcu_bus_pkg::*;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  logic              ne;
  logic              nadv;
  logic              nwe;
  logic              noe;
  logic [AHI_W-1:0]  a_hi;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [DATA_W-1:0] ad_in;

  modport master (
    input  req, wr, addr, wdata, ad_in,
    output busy, ack, rdata, ne, nadv, nwe, noe, a_hi, ad_out, ad_oe
  );

  modport slave (
    output req, wr, addr, wdata, ad_in,
    input  busy, ack, rdata, ne, nadv, nwe, noe, a_hi, ad_out, ad_oe
  );

endinterface

// File: rtl/bus_phase_timer.sv
// Down-counter timing each bus phase: loaded with (cycles-1) on phase entry,
// the phase ends when it reads zero. It parks at zero rather than wrapping.
module bus_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == CNT_W'(1));

endmodule

// File: rtl/mcu_bus_master.sv
// MCU bus initiator: one REQ/ACK transaction at a time through ADDR, AHOLD, DATA, RECOV.
// Every output is a flop loaded from the next-state decode, so the pins never glitch.
module mcu_bus_master
  import mcu_bus_pkg::*;
#(
  parameter int ADDSET  = 2,
  parameter int ADDHLD  = 1,
  parameter int DATAST  = 4,
  parameter int BUSTURN = 1,
  parameter int CNT_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  mcu_bus_master_if.master bus
);

  localparam logic [CNT_W-1:0] ADDSET_LD  = CNT_W'(ADDSET - 1);
  localparam logic [CNT_W-1:0] ADDHLD_LD  = CNT_W'(ADDHLD - 1);
  localparam logic [CNT_W-1:0] DATAST_LD  = CNT_W'(DATAST - 1);
  localparam logic [CNT_W-1:0] BUSTURN_LD = CNT_W'(BUSTURN - 1);

  bus_state_e        state, state_d;
  logic              tmr_load, tmr_zero, tmr_one;
  logic [CNT_W-1:0]  tmr_val;

  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d, ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ne_q, ne_d, nadv_q, nadv_d, nwe_q, nwe_d, noe_q, noe_d;
  logic [AHI_W-1:0]  a_hi_q, a_hi_d;
  logic [DATA_W-1:0] ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d;

  bus_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      ne_q     <= 1'b1;
      nadv_q   <= 1'b1;
      nwe_q    <= 1'b1;
      noe_q    <= 1'b1;
      a_hi_q   <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
    end else begin
      state    <= state_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      ne_q     <= ne_d;
      nadv_q   <= nadv_d;
      nwe_q    <= nwe_d;
      noe_q    <= noe_d;
      a_hi_q   <= a_hi_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
    end
  end

  // Pin values are decided on the edge that enters a phase, so they hold for the whole phase.
  always_comb begin
    state_d  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    ne_d     = ne_q;
    nadv_d   = nadv_q;
    nwe_d    = nwe_q;
    noe_d    = noe_q;
    a_hi_d   = a_hi_q;
    ad_out_d = ad_out_q;
    ad_oe_d  = ad_oe_q;

    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          state_d  = ST_ADDR;
          tmr_load = 1'b1;
          tmr_val  = ADDSET_LD;
          wr_d     = bus.wr;
          wdata_d  = bus.wdata;
          busy_d   = 1'b1;
          ne_d     = 1'b0;
          nadv_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = bus.addr[DATA_W-1:0];
          a_hi_d   = bus.addr[ADDR_W-1:DATA_W];
        end
      end
      ST_ADDR: begin
        if (tmr_zero) begin
          state_d  = ST_AHOLD;
          tmr_load = 1'b1;
          tmr_val  = ADDHLD_LD;
          nadv_d   = 1'b1;
        end
      end
      ST_AHOLD: begin
        if (tmr_zero) begin
          state_d  = ST_DATA;
          tmr_load = 1'b1;
          tmr_val  = DATAST_LD;
          if (wr_q) begin
            ad_out_d = wdata_q;
            ad_oe_d  = 1'b1;
            nwe_d    = 1'b0;
          end else begin
            ad_oe_d  = 1'b0;
            noe_d    = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (tmr_zero) begin
          state_d  = ST_RECOV;
          tmr_load = 1'b1;
          tmr_val  = BUSTURN_LD;
          ne_d     = 1'b1;
          nwe_d    = 1'b1;
          noe_d    = 1'b1;
          ad_oe_d  = wr_q;
          ack_d    = (BUSTURN == 1);
          if (!wr_q) begin
            rdata_d = bus.ad_in;
          end
        end
      end
      ST_RECOV: begin
        // ACK is registered, so it is raised one edge before the final recovery cycle.
        if (tmr_zero) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ad_oe_d = 1'b0;
        end else begin
          ack_d   = tmr_one;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;
  assign bus.ne     = ne_q;
  assign bus.nadv   = nadv_q;
  assign bus.nwe    = nwe_q;
  assign bus.noe    = noe_q;
  assign bus.a_hi   = a_hi_q;
  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_mcu_bus_master.sv
// Self-checking bench for mcu_bus_master: default-timing and all-ones-timing instances,
// a table of transactions checked through a scoreboard, plus hand-written corner sequences.
module tb_mcu_bus_master;
  import mcu_bus_pkg::*;

  typedef struct {
    logic        fast;
    logic        wr;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd_val;
    logic [15:0] exp_ad;
    logic [2:0]  exp_a_hi;
    logic [15:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  mcu_bus_master_if b0();
  mcu_bus_master_if b1();

  mcu_bus_master u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  mcu_bus_master #(.ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(1), .CNT_W(4)) u_dut_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  always #5 clk = ~clk;

  // The emulated target only drives AD while the read strobe is low.
  logic [15:0] rd_val_drv = 16'h0000;
  assign b0.ad_in = (b0.noe == 1'b0) ? rd_val_drv : 16'h0000;
  assign b1.ad_in = (b1.noe == 1'b0) ? rd_val_drv : 16'h0000;

  // Target decoder model: latches the address on the NADV rising edge.
  logic [18:0] latched0 = '0;
  logic [18:0] latched1 = '0;
  always @(posedge b0.nadv) if (b0.ne === 1'b0) latched0 = {b0.a_hi, b0.ad_out};
  always @(posedge b1.nadv) if (b1.ne === 1'b0) latched1 = {b1.a_hi, b1.ad_out};

  int ack_cnt0 = 0;
  int ne_falls0 = 0;
  int viol0 = 0;
  int viol1 = 0;
  always @(posedge clk) if (b0.ack === 1'b1) ack_cnt0++;
  always @(negedge b0.ne) ne_falls0++;
  always @(negedge clk) begin
    if ((b0.nwe === 1'b0 && b0.noe === 1'b0) || (b0.ad_oe === 1'b1 && b0.noe === 1'b0)) viol0++;
    if ((b1.nwe === 1'b0 && b1.noe === 1'b0) || (b1.ad_oe === 1'b1 && b1.noe === 1'b0)) viol1++;
  end

  logic sel_fast = 1'b0;
  logic m_ne, m_nadv, m_nwe, m_noe, m_ad_oe, m_busy, m_ack;
  logic [2:0]  m_a_hi;
  logic [15:0] m_ad_out, m_rdata;
  logic [18:0] m_latched;
  assign m_ne      = sel_fast ? b1.ne     : b0.ne;
  assign m_nadv    = sel_fast ? b1.nadv   : b0.nadv;
  assign m_nwe     = sel_fast ? b1.nwe    : b0.nwe;
  assign m_noe     = sel_fast ? b1.noe    : b0.noe;
  assign m_ad_oe   = sel_fast ? b1.ad_oe  : b0.ad_oe;
  assign m_busy    = sel_fast ? b1.busy   : b0.busy;
  assign m_ack     = sel_fast ? b1.ack    : b0.ack;
  assign m_a_hi    = sel_fast ? b1.a_hi   : b0.a_hi;
  assign m_ad_out  = sel_fast ? b1.ad_out : b0.ad_out;
  assign m_rdata   = sel_fast ? b1.rdata  : b0.rdata;
  assign m_latched = sel_fast ? latched1  : latched0;

  vec_t vecs[8];
  vec_t sb[$];
  int   cyc, ack_cyc, nadv_low, wstb, rstb, addr_bad, data_bad, turn_bad;
  logic busy_at_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic fast, input logic r, input logic w,
                           input logic [18:0] a, input logic [15:0] d);
    if (fast) begin
      b1.req = r; b1.wr = w; b1.addr = a; b1.wdata = d;
    end else begin
      b0.req = r; b0.wr = w; b0.addr = a; b0.wdata = d;
    end
  endtask

  // Issues one request and profiles the bus cycle by cycle until ACK or a 40-cycle budget.
  task automatic apply_stimulus(input vec_t v);
    sel_fast   = v.fast;
    rd_val_drv = v.rd_val;
    @(negedge clk);
    drive_req(v.fast, 1'b1, v.wr, v.addr, v.wdata);
    sb.push_back(v);
    @(negedge clk);
    drive_req(v.fast, 1'b0, 1'b0, 19'h0, 16'h0);
    cyc = 1; ack_cyc = 0; nadv_low = 0; wstb = 0; rstb = 0;
    addr_bad = 0; data_bad = 0; turn_bad = 0; busy_at_ack = 1'b0;
    while (ack_cyc == 0 && cyc <= 40) begin
      if (!m_nadv) begin
        nadv_low++;
        if (m_ad_out !== v.exp_ad || m_a_hi !== v.exp_a_hi || m_ad_oe !== 1'b1) addr_bad++;
      end
      if (!m_nwe) begin
        wstb++;
        if (m_ad_out !== v.wdata || m_ad_oe !== 1'b1) data_bad++;
      end
      if (!m_noe) rstb++;
      if (!v.wr && rstb > 0 && m_ad_oe !== 1'b0) turn_bad++;
      if (m_ack) begin
        ack_cyc     = cyc;
        busy_at_ack = m_busy;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic check_output();
    vec_t v;
    int   lat, addset, datast;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    v      = sb.pop_front();
    lat    = v.fast ? 4 : 8;
    addset = v.fast ? 1 : 2;
    datast = v.fast ? 1 : 4;
    check("ack_latency", ack_cyc, lat);
    check("nadv_low_cycles", nadv_low, addset);
    check("addr_phase_drive", addr_bad, 0);
    check("strobe_cycles", v.wr ? wstb : rstb, datast);
    check("other_strobe", v.wr ? rstb : wstb, 0);
    if (v.wr) check("write_data_drive", data_bad, 0);
    else      check("read_turnaround_oe", turn_bad, 0);
    check("target_latch", m_latched, v.addr);
    check("rdata", m_rdata, v.exp_rdata);
    check("busy_at_ack", busy_at_ack, 1'b1);
    @(negedge clk);
    check("busy_after_ack", m_busy, 1'b0);
    check("ad_oe_after_ack", m_ad_oe, 1'b0);
    check("a_hi_hold_idle", m_a_hi, v.exp_a_hi);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k, d, falls_before, acks_before;

    vecs[0] = '{1'b0, 1'b1, 19'h58400, 16'h1234, 16'h0000, 16'h8400, 3'b101, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 19'h58001, 16'h0000, 16'hBEEF, 16'h8001, 3'b101, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 19'h50123, 16'hA5A5, 16'h0000, 16'h0123, 3'b101, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 19'h7FFFF, 16'h0000, 16'h0F0F, 16'hFFFF, 3'b111, 16'h0F0F};
    vecs[4] = '{1'b0, 1'b1, 19'h00000, 16'hFFFF, 16'h0000, 16'h0000, 3'b000, 16'h0F0F};
    vecs[5] = '{1'b0, 1'b0, 19'h58002, 16'h0000, 16'h5A5A, 16'h8002, 3'b101, 16'h5A5A};
    vecs[6] = '{1'b1, 1'b1, 19'h58800, 16'h1357, 16'h0000, 16'h8800, 3'b101, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 19'h58800, 16'h0000, 16'h2468, 16'h8800, 3'b101, 16'h2468};

    drive_req(1'b0, 1'b0, 1'b0, 19'h0, 16'h0);
    drive_req(1'b1, 1'b0, 1'b0, 19'h0, 16'h0);

    repeat (3) @(negedge clk);
    check("reset_ne", b0.ne, 1'b1);
    check("reset_nadv", b0.nadv, 1'b1);
    check("reset_strobes", {b0.nwe, b0.noe}, 2'b11);
    check("reset_ad", {b0.ad_oe, b0.ad_out, b0.a_hi}, 20'h0);
    check("reset_busy_ack", {b0.busy, b0.ack}, 2'b00);
    check("reset_rdata", b0.rdata, 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      check_output();
    end
    sel_fast = 1'b0;

    // A request arriving while busy must be dropped, not queued.
    falls_before = ne_falls0;
    acks_before  = ack_cnt0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b1, 19'h58400, 16'h1111);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 19'h0, 16'h0);
    repeat (2) @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 19'h58002, 16'h0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 19'h0, 16'h0);
    repeat (20) @(negedge clk);
    check("ignored_req_ne_falls", ne_falls0 - falls_before, 1);
    check("ignored_req_acks", ack_cnt0 - acks_before, 1);
    check("ignored_req_latch", latched0, 19'h58400);

    // REQ held high: second transaction starts in the idle cycle after ACK.
    falls_before = ne_falls0;
    acks_before  = ack_cnt0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b1, 19'h58400, 16'h0001);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (b0.ack !== 1'b1 && k < 20);
    check("b2b_first_ack", b0.ack, 1'b1);
    b0.wdata = 16'h0002;
    d = 0;
    while (b0.ne !== 1'b0 && d < 10) begin
      @(negedge clk);
      d++;
    end
    check("b2b_ne_gap", d, 2);
    drive_req(1'b0, 1'b0, 1'b0, 19'h0, 16'h0);
    repeat (15) @(negedge clk);
    check("b2b_acks", ack_cnt0 - acks_before, 2);
    check("b2b_ne_falls", ne_falls0 - falls_before, 2);

    // Reset during the data phase of a write aborts it with no ACK.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b1, 19'h58400, 16'hCAFE);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 19'h0, 16'h0);
    k = 0;
    while (b0.nwe !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_data", b0.nwe, 1'b0);
    acks_before = ack_cnt0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {b0.ne, b0.nadv, b0.nwe, b0.noe}, 4'b1111);
    check("rst_mid_ad_oe", b0.ad_oe, 1'b0);
    check("rst_mid_busy", b0.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_no_ack", ack_cnt0 - acks_before, 0);
    check("rst_rdata_cleared", b0.rdata, 16'h0);
    apply_stimulus(vecs[0]);
    check_output();

    check("no_overlap_default", viol0, 0);
    check("no_overlap_fast", viol1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
